// File: rtl/serializer_pkg.sv
// Shared types and constants for the word-to-UART serializer.
// Build option: SERIALIZER_PARITY_EN adds an even-parity bit to every frame.
package serializer_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_START_BITS = 1;
  localparam int unsigned UART_STOP_BITS  = 1;

`ifdef SERIALIZER_PARITY_EN
  localparam int unsigned UART_PARITY_BITS = 1;
`else
  localparam int unsigned UART_PARITY_BITS = 0;
`endif

  localparam int unsigned UART_FRAME_BITS =
    UART_START_BITS + UART_DATA_BITS + UART_PARITY_BITS + UART_STOP_BITS;

  // Counter width helper that never returns zero.
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_transmit.sv
// Bit-level UART transmitter: one byte per frame, chained frames without idle gap.
// Build option: SERIALIZER_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_transmit
  import serializer_pkg::*;
#(
  parameter int unsigned BIT_PERIOD = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      byte_valid,
  input  logic [UART_DATA_BITS-1:0] byte_data,
  output logic                      byte_ready_c,
  output logic                      byte_done_c,
  output logic                      tx
);

  localparam int unsigned BAUD_W = $clog2(BIT_PERIOD);
  localparam int unsigned BIT_W  = $clog2(UART_DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_PERIOD - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

  tx_state_t                 state_q, state_d;
  logic [BAUD_W-1:0]         baud_q, baud_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      bit_end;
`ifdef SERIALIZER_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= TX_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state and next-line-level; tx_d is registered so the pin never glitches.
  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    tx_d         = tx_q;
`ifdef SERIALIZER_PARITY_EN
    parity_d     = parity_q;
`endif
    byte_ready_c = 1'b0;
    byte_done_c  = 1'b0;
    bit_end      = (baud_q == BAUD_LAST);

    if (state_q != TX_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      TX_IDLE: begin
        byte_ready_c = 1'b1;
        tx_d         = 1'b1;
      end
      TX_START: begin
        if (bit_end) begin
          state_d = TX_DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
`ifdef SERIALIZER_PARITY_EN
            state_d = TX_PARITY;
            tx_d    = parity_q;
`else
            state_d = TX_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
          end
        end
      end
`ifdef SERIALIZER_PARITY_EN
      TX_PARITY: begin
        if (bit_end) begin
          state_d = TX_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (bit_end) begin
          byte_done_c  = 1'b1;
          byte_ready_c = 1'b1;
          state_d      = TX_IDLE;
          tx_d         = 1'b1;
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // A byte offered while ready starts its start bit on the very next cycle.
    if (byte_ready_c && byte_valid) begin
      state_d  = TX_START;
      tx_d     = 1'b0;
      baud_d   = '0;
      shift_d  = byte_data;
`ifdef SERIALIZER_PARITY_EN
      parity_d = ^byte_data;
`endif
    end
  end

  assign tx = tx_q;

endmodule

// File: rtl/serializer.sv
// Word serializer: sends a DATA_BYTES-wide word as back-to-back UART frames, LSB byte first.
// Build option: SERIALIZER_PARITY_EN switches frames from 8N1 to 8E1.
module serializer
  import serializer_pkg::*;
#(
  parameter int unsigned DATA_BYTES       = 4,
  parameter int unsigned BAUD_RATE        = 9600,
  parameter int unsigned INPUT_CLOCK_FREQ = 100_000_000
) (
  input  logic                               clk_in,
  input  logic                               rst_n_in,
  input  logic                               valid_in,
  input  logic [UART_DATA_BITS*DATA_BYTES-1:0] data_in,
  output logic                               ready_out,
  output logic                               busy_out,
  output logic                               done_out,
  output logic                               tx_wire_out
);

  localparam int unsigned BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned WORD_W     = UART_DATA_BITS * DATA_BYTES;
  localparam int unsigned IDX_W      = min1_clog2(DATA_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BYTES - 1);

  logic [WORD_W-1:0]         shift_q;
  logic [WORD_W-1:0]         shifted;
  logic [IDX_W-1:0]          idx_q;
  logic                      ready_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      accept;
  logic                      last_byte;
  logic                      byte_valid;
  logic                      byte_ready;
  logic                      byte_done;
  logic [UART_DATA_BITS-1:0] byte_data;

  assign accept    = valid_in && ready_q && byte_ready;
  assign last_byte = (idx_q == IDX_LAST);
  assign shifted   = shift_q >> UART_DATA_BITS;

  // First byte goes straight from data_in so the start bit follows the accept edge.
  assign byte_valid = accept || (busy_q && byte_done && !last_byte);
  assign byte_data  = accept ? data_in[UART_DATA_BITS-1:0] : shifted[UART_DATA_BITS-1:0];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      shift_q <= '0;
      idx_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        shift_q <= data_in;
        idx_q   <= '0;
        ready_q <= 1'b0;
        busy_q  <= 1'b1;
      end else if (busy_q && byte_done) begin
        if (last_byte) begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          done_q  <= 1'b1;
        end else begin
          shift_q <= shifted;
          idx_q   <= idx_q + 1'b1;
        end
      end
    end
  end

  uart_transmit #(
    .BIT_PERIOD (BIT_PERIOD)
  ) u_uart_transmit (
    .clk          (clk_in),
    .rst_n        (rst_n_in),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready_c (byte_ready),
    .byte_done_c  (byte_done),
    .tx           (tx_wire_out)
  );

  assign ready_out = ready_q;
  assign busy_out  = busy_q;
  assign done_out  = done_q;

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: line waveform compared against a per-cycle frame model.
// Build option: SERIALIZER_PARITY_EN enables the parity-frame scenario.
`timescale 1ns/1ps
module tb_serializer;

  localparam int unsigned DATA_BYTES = 4;
  localparam int unsigned BAUD       = 100_000;
  localparam int unsigned FREQ       = 1_000_000;
  localparam int unsigned BP         = FREQ / BAUD;
`ifdef SERIALIZER_PARITY_EN
  localparam int unsigned FRAME = 11;
`else
  localparam int unsigned FRAME = 10;
`endif
  localparam int unsigned NCYC = DATA_BYTES * FRAME * BP;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] data  = '0;
  logic        ready, busy, done, tx;
  logic        line_log [0:NCYC];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  serializer #(
    .DATA_BYTES       (DATA_BYTES),
    .BAUD_RATE        (BAUD),
    .INPUT_CLOCK_FREQ (FREQ)
  ) dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .valid_in    (valid),
    .data_in     (data),
    .ready_out   (ready),
    .busy_out    (busy),
    .done_out    (done),
    .tx_wire_out (tx)
  );

  // Expected line level k cycles after the accept edge (k=1 is the first start-bit cycle).
  function automatic logic exp_tx(input logic [31:0] w, input int unsigned k);
    int unsigned bitn, byten, pos;
    logic [7:0]  b;
    bitn  = (k - 1) / BP;
    byten = bitn / FRAME;
    pos   = bitn % FRAME;
    b     = 8'(w >> (8 * byten));
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[3'(pos - 1)];
    if (FRAME == 11 && pos == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < 2000) begin
      cycle();
      n++;
    end
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_timeout: ready=%b expected 1", tag, ready);
    end
  endtask

  // Sends w (or lets a pre-driven valid be accepted) and checks the whole transfer.
  task automatic transmit(input logic [31:0] w, input bit preloaded, input bit hold,
                          input logic [31:0] next_w, input string tag);
    int line_err = 0, hs_err = 0, early = 0, first_bad = 0;
    if (!preloaded) begin
      wait_ready(tag);
      valid = 1'b1;
      data  = w;
    end
    cycle();
    if (hold) begin
      valid = 1'b1;
      data  = next_w;
    end else begin
      valid = 1'b0;
      data  = $urandom;
    end
    for (int k = 1; k <= int'(NCYC); k++) begin
      line_log[k] = tx;
      if (tx !== exp_tx(w, k)) begin
        if (line_err == 0) first_bad = k;
        line_err++;
      end
      if (ready !== 1'b0 || busy !== 1'b1) hs_err++;
      if (done !== 1'b0) early++;
      cycle();
    end
    total++;
    if (line_err != 0) begin
      bad++;
      $display("FAIL %s line: %0d wrong cycles, first at cycle %0d, word %h", tag, line_err, first_bad, w);
    end
    total++;
    if (hs_err != 0) begin
      bad++;
      $display("FAIL %s handshake: %0d cycles not ready=0/busy=1", tag, hs_err);
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL %s early_done: done high in %0d transfer cycles, expected 0", tag, early);
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL %s done_timing: done=%b at accept+%0d, expected 1", tag, done, NCYC + 1);
    end
    total++;
    if (ready !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
      bad++;
      $display("FAIL %s done_cycle_state: ready=%b busy=%b tx=%b, expected 1 0 1", tag, ready, busy, tx);
    end
  endtask

  task automatic test_reset();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: tx=%b ready=%b busy=%b done=%b, expected 1 1 0 0", tx, ready, busy, done);
    end
    repeat (3) cycle();
    total++;
    if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: tx=%b ready=%b busy=%b done=%b, expected 1 1 0 0", tx, ready, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle();
    total++;
    if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_idle: tx=%b ready=%b busy=%b, expected 1 1 0", tx, ready, busy);
    end
  endtask

  task automatic test_hold_valid();
    transmit(32'hDEADBEEF, 1'b0, 1'b1, 32'h12345678, "deadbeef");
    transmit(32'h12345678, 1'b1, 1'b0, 32'h0, "held_word");
  endtask

  task automatic test_back_to_back();
    transmit($urandom, 1'b0, 1'b1, 32'h00000001, "b2b_first");
    transmit(32'h00000001, 1'b1, 1'b0, 32'h0, "b2b_second");
    total++;
    if (line_log[1] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_no_gap: tx=%b on cycle after done-cycle accept, expected 0", line_log[1]);
    end
  endtask

  task automatic test_reset_mid();
    int done_seen = 0;
    wait_ready("reset_mid");
    valid = 1'b1;
    data  = 32'hCAFEF00D;
    cycle();
    valid = 1'b0;
    repeat (FRAME * BP + 14) cycle();
    total++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_pre: tx=%b busy=%b in second byte, expected 0 1", tx, busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_async: tx=%b ready=%b busy=%b done=%b, expected 1 1 0 0", tx, ready, busy, done);
    end
    repeat (4) cycle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < int'(NCYC); i++) begin
      cycle();
      if (done !== 1'b0 || tx !== 1'b1) done_seen++;
    end
    total++;
    if (done_seen != 0) begin
      bad++;
      $display("FAIL reset_mid_quiet: %0d cycles with done or line activity after reset, expected 0", done_seen);
    end
    transmit(32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 20)) cycle();
      transmit($urandom, 1'b0, 1'b0, 32'h0, "random");
    end
  endtask

`ifdef SERIALIZER_PARITY_EN
  task automatic test_parity();
    transmit(32'h00000007, 1'b0, 1'b0, 32'h0, "parity");
    total++;
    if (line_log[9 * BP + 1] !== 1'b1) begin
      bad++;
      $display("FAIL parity_byte0: parity bit=%b, expected 1", line_log[9 * BP + 1]);
    end
    total++;
    if (line_log[(FRAME + 9) * BP + 1] !== 1'b0) begin
      bad++;
      $display("FAIL parity_byte1: parity bit=%b, expected 0", line_log[(FRAME + 9) * BP + 1]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_hold_valid();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef SERIALIZER_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
